mem_if: RTL and testbench
=========================

MEM_IF -- requirements
Module: mem_if

Interface
REQ-001 The block SHALL sit downstream of the multicycle controller, sequencing every IRWrite/MemWrite/load access over a variable-latency req/ack memory bus and stalling the controller until each access completes.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, maximum BUSY cycles allowed before an access is abandoned (only meaningful with MEM_TIMEOUT_EN).
REQ-003 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset.
REQ-005 Port: Adr  in  32  byte address selected by AdrSrc upstream.
REQ-006 Port: WriteData  in  32  store data.
REQ-007 Port: IRWrite  in  1  instruction fetch request.
REQ-008 Port: MemWrite  in  1  data store request.
REQ-009 Port: MemRead  in  1  data load request.
REQ-010 Port: Instr  out  32  instruction register.
REQ-011 Port: Data  out  32  load data register.
REQ-012 Port: Stall  out  1  controller must hold its current state and outputs while high.
REQ-013 Port: MemErr  out  1  sticky access-timeout flag.
REQ-014 Ports: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ack in 1 (memory bus).

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 IDLE: when any request is high, latch word address {Adr[31:2],2'b00}, WriteData and access type, then go to BUSY; no request: stay IDLE.
REQ-017 Request priority when several are high SHALL be IRWrite > MemWrite > MemRead; lower-priority requests are dropped, not queued.
REQ-018 Stall SHALL equal (IDLE and any request) OR BUSY, combinationally; Stall SHALL be 0 in DONE.
REQ-019 BUSY: mem_req=1, with mem_addr/mem_we/mem_wdata driven from latched values and held stable until mem_ack is sampled high.
REQ-020 On mem_ack in BUSY: fetch loads Instr<=mem_rdata, load loads Data<=mem_rdata, store loads neither; go to DONE.
REQ-021 DONE SHALL last exactly one cycle, ignore all requests (the controller's still-held request must not restart an access), then return to IDLE.
REQ-022 Minimum latency: request seen in cycle N, mem_req in N+1, ack in N+1, register updated and Stall=0 in N+2.
REQ-023 mem_ack outside BUSY SHALL be ignored.
REQ-024 Instr and Data SHALL change only on an acknowledged access of the matching type.

Reset
REQ-025 reset low at a clock edge: state=IDLE, Instr=0, Data=0, MemErr=0, latched address/data=0, timeout counter=0.
REQ-026 Reset in BUSY SHALL drop mem_req on the next cycle and discard the access; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN defined: a counter SHALL increment each BUSY cycle without ack; when it reaches TIMEOUT_CYCLES, drop mem_req, set MemErr (sticky until reset), leave Instr/Data unchanged, and go to DONE.
REQ-028 MEM_TIMEOUT_EN undefined: no counter, MemErr tied to 0, BUSY waits indefinitely for mem_ack.

Structure
REQ-029 The shared package SHALL hold the FSM state enum, the access-type encoding (FETCH/LOAD/STORE) and the default TIMEOUT_CYCLES constant.
REQ-030 The timeout counter SHALL be a sub-module mem_timeout, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-031 Fetch with zero wait: IRWrite=1, Adr=0x00000006, mem_ack in first BUSY cycle with rdata=0xE2810001 -> mem_addr=0x00000004, Stall high 2 cycles, Instr=0xE2810001 in cycle N+2.
REQ-032 Store with 3-cycle wait: MemWrite=1, Adr=0x100, WriteData=0xDEADBEEF -> mem_we=1, addr/wdata stable for 3 cycles, Instr/Data unchanged.
REQ-033 Simultaneous IRWrite+MemRead -> exactly one fetch access, Data unchanged; held IRWrite in DONE starts no second access.
REQ-034 Reset asserted in 2nd BUSY cycle, ack 1 cycle later -> mem_req=0, state IDLE, Instr=0, ack ignored.
REQ-035 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, MemErr=1 and stays 1 until reset, Stall=0 in DONE.
REQ-036 Load with rdata=0x12345678, spurious mem_ack in IDLE beforehand -> Data=0x12345678 only after the BUSY-state ack.

Source files
------------

// File: rtl/mem_if_pkg.sv
// mem_if_pkg -- shared definitions for the memory-interface sequencer.
//   state_e   : sequencer FSM states (IDLE / BUSY / DONE)
//   acc_e     : latched access type (FETCH / LOAD / STORE)
//   TIMEOUT_CYCLES_DEFAULT : default BUSY-cycle limit before an access is abandoned
//   word_addr : aligns a byte address down to its 32-bit word
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } acc_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// mem_timeout -- counts consecutive un-acknowledged BUSY cycles.
//   clk, reset  : clock, synchronous active-low reset
//   busy_i      : sequencer is in BUSY this cycle
//   ack_i       : memory acknowledged this cycle
//   expired_o   : this is the TIMEOUT_CYCLES-th BUSY cycle and still no ack
// TIMEOUT_CYCLES must be at least 1.
module mem_timeout
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic busy_i,
    input  logic ack_i,
    output logic expired_o
);

    logic [31:0] cnt_q, cnt_d;

    // Counter restarts from zero whenever the access ends or was never running.
    always_comb begin
        cnt_d = '0;
        if (busy_i && !ack_i) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // An ack arriving on the last allowed cycle still wins over the timeout.
    assign expired_o = busy_i && !ack_i && (cnt_q == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/mem_if.sv
// mem_if -- sequences fetch / store / load accesses from the multicycle
// controller over a variable-latency req/ack memory bus, stalling the
// controller until each access completes.
//   clk, reset                : clock, synchronous active-low reset
//   Adr, WriteData            : byte address and store data from the datapath
//   IRWrite, MemWrite, MemRead: fetch / store / load requests (priority in that order)
//   Instr, Data               : instruction and load-data registers
//   Stall                     : controller must hold while high
//   MemErr                    : sticky access-timeout flag
//   mem_req/we/addr/wdata     : memory bus request side
//   mem_rdata, mem_ack        : memory bus response side
// Optional feature macro MEM_TIMEOUT_EN: abandon an access after
// TIMEOUT_CYCLES un-acknowledged BUSY cycles and raise MemErr. Without it
// MemErr is tied low and BUSY waits indefinitely.
module mem_if
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        IRWrite,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] Instr,
    output logic [31:0] Data,
    output logic        Stall,
    output logic        MemErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("mem_if: TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    acc_e        acc_q, acc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic        any_req;
    logic        timeout_hit;

    assign any_req = IRWrite | MemWrite | MemRead;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // DONE always falls back to IDLE so a request the stalled controller is
    // still holding cannot start a second access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Stall   = ((state_q == IDLE) && any_req) || (state_q == BUSY);
        mem_req = (state_q == BUSY);
        mem_we  = (state_q == BUSY) && (acc_q == STORE);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign Instr     = instr_q;
    assign Data      = data_q;

    // ---------------- request latch and result registers ----------------
    always_comb begin
        acc_d   = acc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        data_d  = data_q;
        if ((state_q == IDLE) && any_req) begin
            addr_d  = word_addr(Adr);
            wdata_d = WriteData;
            if (IRWrite)       acc_d = FETCH;
            else if (MemWrite) acc_d = STORE;
            else               acc_d = LOAD;
        end
        if ((state_q == BUSY) && mem_ack) begin
            if (acc_q == FETCH) instr_d = mem_rdata;
            if (acc_q == LOAD)  data_d  = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q   <= FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            data_q  <= data_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic memerr_q, memerr_d;

    mem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .busy_i    (state_q == BUSY),
        .ack_i     (mem_ack),
        .expired_o (timeout_hit)
    );

    assign memerr_d = memerr_q | timeout_hit;

    always_ff @(posedge clk) begin
        if (!reset) memerr_q <= 1'b0;
        else        memerr_q <= memerr_d;
    end

    assign MemErr = memerr_q;
`else
    assign timeout_hit = 1'b0;
    assign MemErr      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_if.sv
// tb_mem_if -- self-checking bench for mem_if. The bench plays both the
// controller and the memory; a word array is the memory model and the
// expected Instr/Data/MemErr values follow from the request priority rules.
module tb_mem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Adr, WriteData;
    logic        IRWrite, MemWrite, MemRead;
    logic [31:0] Instr, Data;
    logic        Stall, MemErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [64];
    logic [31:0] exp_instr, exp_data;
    logic        exp_err;

    mem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Adr       (Adr),
        .WriteData (WriteData),
        .IRWrite   (IRWrite),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Instr     (Instr),
        .Data      (Data),
        .Stall     (Stall),
        .MemErr    (MemErr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access as the controller sees it: request in cycle N,
    // held through BUSY and DONE, dropped once back in IDLE. The memory acks
    // after wait_cyc extra BUSY cycles. Caller must be in IDLE.
    task automatic do_access(input bit irw, input bit mw, input bit mr,
                             input logic [31:0] adr, input logic [31:0] wd,
                             input int wait_cyc);
        logic [31:0] wa;
        bit          is_f, is_s, is_l;
        wa   = {adr[31:2], 2'b00};
        is_f = irw;
        is_s = !irw && mw;
        is_l = !irw && !mw && mr;
        IRWrite = irw; MemWrite = mw; MemRead = mr;
        Adr = adr; WriteData = wd; mem_ack = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errors++; $display("FAIL stall_on_req got=%b exp=1", Stall);
        end
        for (int c = 0; c <= wait_cyc; c++) begin
            step();
            if (c == wait_cyc) begin mem_ack = 1'b1; mem_rdata = mem[wa[7:2]]; end
            else               begin mem_ack = 1'b0; mem_rdata = $urandom; end
            #1;
            checks++;
            if ({Stall, mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, is_s, wa}) begin
                errors++;
                $display("FAIL busy_bus got stall=%b req=%b we=%b addr=%h exp stall=1 req=1 we=%b addr=%h",
                         Stall, mem_req, mem_we, mem_addr, is_s, wa);
            end
            if (is_s) begin
                checks++;
                if (mem_wdata !== wd) begin
                    errors++; $display("FAIL busy_wdata got=%h exp=%h", mem_wdata, wd);
                end
            end
        end
        step();
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (is_f) exp_instr = mem[wa[7:2]];
        if (is_l) exp_data  = mem[wa[7:2]];
        if (is_s) mem[wa[7:2]] = wd;
        #1;
        checks++;
        if ({Stall, mem_req} !== 2'b00) begin
            errors++; $display("FAIL done_stall got stall=%b req=%b exp 0 0", Stall, mem_req);
        end
        checks++;
        if ({Instr, Data, MemErr} !== {exp_instr, exp_data, exp_err}) begin
            errors++;
            $display("FAIL result_regs got instr=%h data=%h err=%b exp instr=%h data=%h err=%b",
                     Instr, Data, MemErr, exp_instr, exp_data, exp_err);
        end
        step();
        IRWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        #1;
        checks++;
        if ({Stall, mem_req} !== 2'b00) begin
            errors++; $display("FAIL no_restart got stall=%b req=%b exp 0 0", Stall, mem_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        IRWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        Adr = '0; WriteData = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        exp_instr = '0; exp_data = '0; exp_err = 1'b0;
        checks++;
        if ({Instr, Data, MemErr, Stall, mem_req, mem_we} !== {64'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_state got instr=%h data=%h err=%b stall=%b req=%b we=%b exp all 0",
                     Instr, Data, MemErr, Stall, mem_req, mem_we);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        mem[1] = 32'hE281_0001;
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 0);
        checks++;
        if (Instr !== 32'hE281_0001) begin
            errors++; $display("FAIL fetch_instr got=%h exp=e2810001", Instr);
        end
    endtask

    task automatic test_store();
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2);
    endtask

    task automatic test_priority();
        do_access(1'b1, 1'b0, 1'b1, 32'h0000_0048, 32'h1111_2222, 1);
        do_access(1'b0, 1'b1, 1'b1, 32'h0000_0049, 32'h3333_4444, 0);
    endtask

    task automatic test_reset_busy();
        mem[8] = 32'hCAFE_F00D;
        IRWrite = 1'b1; Adr = 32'h0000_0020;
        step();                       // BUSY, 1st cycle
        step();                       // BUSY, 2nd cycle: assert reset
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_busy_req_before got=%b exp=1", mem_req);
        end
        step();                       // reset taken; late ack arrives now
        reset = 1'b1; IRWrite = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        exp_instr = '0; exp_data = '0; exp_err = 1'b0;
        #1;
        checks++;
        if ({mem_req, Stall, Instr} !== {2'b00, 32'd0}) begin
            errors++;
            $display("FAIL rst_busy_after got req=%b stall=%b instr=%h exp 0 0 0", mem_req, Stall, Instr);
        end
        step();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, Instr, Data} !== {1'b0, 64'd0}) begin
            errors++;
            $display("FAIL rst_late_ack got req=%b instr=%h data=%h exp 0 0 0", mem_req, Instr, Data);
        end
    endtask

    task automatic test_spurious_ack();
        mem[5] = 32'h1234_5678;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step(); step();
        checks++;
        if ({Data, Stall, mem_req} !== {exp_data, 2'b00}) begin
            errors++;
            $display("FAIL idle_ack got data=%h stall=%b req=%b exp data=%h 0 0", Data, Stall, mem_req, exp_data);
        end
        mem_ack = 1'b0;
        do_access(1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'h0, 1);
        checks++;
        if (Data !== 32'h1234_5678) begin
            errors++; $display("FAIL load_data got=%h exp=12345678", Data);
        end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        IRWrite = 1'b1; Adr = 32'h0000_0030;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({mem_req, Stall} !== 2'b11) begin
                errors++; $display("FAIL to_busy cyc=%0d got req=%b stall=%b exp 1 1", c, mem_req, Stall);
            end
        end
        step();
        exp_err = 1'b1;
        checks++;
        if ({mem_req, Stall, MemErr, Instr} !== {3'b001, exp_instr}) begin
            errors++;
            $display("FAIL to_done got req=%b stall=%b err=%b instr=%h exp 0 0 1 %h",
                     mem_req, Stall, MemErr, Instr, exp_instr);
        end
        step();
        IRWrite = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (MemErr !== 1'b1) begin
                errors++; $display("FAIL to_sticky got=%b exp=1", MemErr);
            end
        end
        do_access(1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'h0, 3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_instr = '0; exp_data = '0; exp_err = 1'b0;
        checks++;
        if ({MemErr, Instr, Data} !== {1'b0, 64'd0}) begin
            errors++; $display("FAIL to_reset got err=%b instr=%h data=%h exp 0 0 0", MemErr, Instr, Data);
        end
        step();
`else
        // Without the timeout, a long wait must simply be ridden out.
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 20);
`endif
    endtask

    task automatic test_random();
        bit          irw, mw, mr;
        logic [31:0] adr, wd;
        for (int i = 0; i < 40; i++) begin
            irw = 1'($urandom); mw = 1'($urandom); mr = 1'($urandom);
            if (!(irw || mw || mr)) mr = 1'b1;
            adr = $urandom; wd = $urandom;
            do_access(irw, mw, mr, adr, wd, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1; mem_rdata = $urandom;
                step();
                mem_ack = 1'b0;
                #1;
                checks++;
                if ({Instr, Data, mem_req} !== {exp_instr, exp_data, 1'b0}) begin
                    errors++;
                    $display("FAIL rand_idle_ack got instr=%h data=%h req=%b exp %h %h 0",
                             Instr, Data, mem_req, exp_instr, exp_data);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_reset_busy();
        test_spurious_ack();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
